elevator_floor_ctrl: RTL



---
 rtl/elevator_floor_ctrl_if.sv | 23 ++
 rtl/elevator_floor_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/elevator_floor_ctrl_if.sv
// Call inputs plus display/observe outputs of the elevator car controller.
// The estop signal exists only when ELEVATOR_ESTOP_EN is defined.
interface elevator_floor_ctrl_if;
  logic [7:0] call_req;
  logic [2:0] floor;
  logic [1:0] status;
  logic       disp_sel;
  logic [7:0] pending;
  logic       busy;
`ifdef ELEVATOR_ESTOP_EN
  logic       estop;

  modport master (output call_req, estop,
                  input  floor, status, disp_sel, pending, busy);
  modport slave  (input  call_req, estop,
                  output floor, status, disp_sel, pending, busy);
`else
  modport master (output call_req,
                  input  floor, status, disp_sel, pending, busy);
  modport slave  (input  call_req,
                  output floor, status, disp_sel, pending, busy);
`endif
endinterface

// File: rtl/elevator_floor_ctrl.sv
// SCAN-ordered elevator car controller with registered floor/status/display-select outputs.
// Defining ELEVATOR_ESTOP_EN adds an emergency-stop input that freezes travel and door timing.
module elevator_floor_ctrl #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input logic                  clk,
  input logic                  rst,
  elevator_floor_ctrl_if.slave bus
);
  // state     | meaning
  // IDLE      | no outstanding work, door closed, display shows floor
  // MOVE_UP   | travelling up, one floor per TRAVEL_CYCLES
  // MOVE_DOWN | travelling down, one floor per TRAVEL_CYCLES
  // DOOR_OPEN | stopped at a served floor for DOOR_CYCLES
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MOVE_UP   = 2'b01,
    MOVE_DOWN = 2'b10,
    DOOR_OPEN = 2'b11
  } state_t;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);
  localparam logic [7:0]    VALID_MASK  = 8'((16'd1 << NUM_FLOORS) - 16'd1);

  state_t          state_q, state_d;
  dir_t            last_dir_q, last_dir_d;
  logic [2:0]      floor_q, floor_d;
  logic [TW-1:0]   travel_q, travel_d;
  logic [DW-1:0]   door_q, door_d;
  logic [7:0]      pending_q, pending_d;
  logic [1:0]      status_q, status_d;
  logic            disp_sel_q, disp_sel_d;

  logic [7:0]      calls, clear_mask, above_mask, below_mask;
  logic [3:0]      up_shift;
  logic [2:0]      floor_up, floor_dn;
  logic            above, below, here, pick_up, pick_down;

  assign calls      = bus.call_req & VALID_MASK;
  assign up_shift   = {1'b0, floor_q} + 4'd1;
  assign above_mask = 8'hFF << up_shift;
  assign below_mask = (8'h01 << floor_q) - 8'h01;
  assign above      = |(pending_q & above_mask);
  assign below      = |(pending_q & below_mask);
  assign here       = pending_q[floor_q];
  assign floor_up   = floor_q + 3'd1;
  assign floor_dn   = floor_q - 3'd1;

  // Keep going the way we last travelled while calls lie ahead, otherwise reverse.
  assign pick_up    = above & ((last_dir_q == DIR_UP) | ~below);
  assign pick_down  = below & ~pick_up;

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    last_dir_d = last_dir_q;
    travel_d   = travel_q;
    door_d     = door_q;
    clear_mask = 8'h00;
    status_d   = 2'b00;
    disp_sel_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (here) begin
          state_d    = DOOR_OPEN;
          door_d     = '0;
          clear_mask = 8'h01 << floor_q;
        end else if (pick_up) begin
          state_d    = MOVE_UP;
          last_dir_d = DIR_UP;
          travel_d   = '0;
        end else if (pick_down) begin
          state_d    = MOVE_DOWN;
          last_dir_d = DIR_DOWN;
          travel_d   = '0;
        end
      end
      MOVE_UP: begin
        if (travel_q == TRAVEL_LAST) begin
          floor_d  = floor_up;
          travel_d = '0;
          if (pending_q[floor_up]) begin
            state_d    = DOOR_OPEN;
            door_d     = '0;
            clear_mask = 8'h01 << floor_up;
          end
        end else begin
          travel_d = travel_q + 1'b1;
        end
      end
      MOVE_DOWN: begin
        if (travel_q == TRAVEL_LAST) begin
          floor_d  = floor_dn;
          travel_d = '0;
          if (pending_q[floor_dn]) begin
            state_d    = DOOR_OPEN;
            door_d     = '0;
            clear_mask = 8'h01 << floor_dn;
          end
        end else begin
          travel_d = travel_q + 1'b1;
        end
      end
      DOOR_OPEN: begin
        // A fresh call for this floor keeps the door open for a full dwell.
        if (calls[floor_q]) begin
          door_d     = '0;
          clear_mask = 8'h01 << floor_q;
        end else if (door_q == DOOR_LAST) begin
          if (pick_up) begin
            state_d    = MOVE_UP;
            last_dir_d = DIR_UP;
            travel_d   = '0;
          end else if (pick_down) begin
            state_d    = MOVE_DOWN;
            last_dir_d = DIR_DOWN;
            travel_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          door_d = door_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ELEVATOR_ESTOP_EN
    if (bus.estop) begin
      state_d    = state_q;
      floor_d    = floor_q;
      last_dir_d = last_dir_q;
      travel_d   = travel_q;
      door_d     = door_q;
      clear_mask = 8'h00;
    end
`endif

    pending_d = (pending_q | calls) & ~clear_mask;

    case (state_d)
      MOVE_UP:   status_d = 2'b01;
      MOVE_DOWN: status_d = 2'b10;
      DOOR_OPEN: status_d = 2'b11;
      default:   status_d = 2'b00;
    endcase
    disp_sel_d = (state_d != IDLE);

`ifdef ELEVATOR_ESTOP_EN
    if (bus.estop) begin
      status_d   = 2'b11;
      disp_sel_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      floor_q    <= 3'd0;
      last_dir_q <= DIR_UP;
      travel_q   <= '0;
      door_q     <= '0;
      pending_q  <= 8'h00;
      status_q   <= 2'b00;
      disp_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      last_dir_q <= last_dir_d;
      travel_q   <= travel_d;
      door_q     <= door_d;
      pending_q  <= pending_d;
      status_q   <= status_d;
      disp_sel_q <= disp_sel_d;
    end
  end

  assign bus.floor    = floor_q;
  assign bus.status   = status_q;
  assign bus.disp_sel = disp_sel_q;
  assign bus.busy     = disp_sel_q;
  assign bus.pending  = pending_q;

endmodule
